// File: rtl/mips_mem_pkg.sv
// Shared definitions for the sized MIPS data memory: access size codes,
// controller state encoding and a constant log2 helper for parameter math.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // Ceiling log2, never below 1 so derived vectors always have a legal width.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mips_load_align.sv
// Combinational lane steering: byte enables and shifted store data for a
// write, extracted and extended load data for a read, plus alignment legality.
module mips_load_align
  import mips_mem_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int NB    = WIDTH / 8,
  localparam int OFF_W = clog2_f(NB)
) (
  input  logic [1:0]       i_size,
  input  logic [OFF_W-1:0] i_off,
  input  logic [WIDTH-1:0] i_wd,
  input  logic [WIDTH-1:0] i_raw,
  input  logic             i_sign_ext,
  output logic [NB-1:0]    o_be,
  output logic [WIDTH-1:0] o_st_data,
  output logic [WIDTH-1:0] o_ld_data,
  output logic             o_legal
);

  logic [NB-1:0]      w_mask;
  logic [OFF_W+2:0]   w_shamt;
  logic [WIDTH-1:0]   w_raw_sh;

  assign w_shamt   = {i_off, 3'b000};
  assign o_be      = w_mask << i_off;
  assign o_st_data = i_wd << w_shamt;
  assign w_raw_sh  = i_raw >> w_shamt;

  always_comb begin
    w_mask  = '0;
    o_legal = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        w_mask  = NB'(1);
        o_legal = 1'b1;
      end
      SZ_HALF: begin
        w_mask  = NB'(3);
        o_legal = ~i_off[0];
      end
      SZ_WORD: begin
        w_mask  = '1;
        o_legal = (i_off == '0);
      end
      default: begin
        w_mask  = '0;
        o_legal = 1'b0;
      end
    endcase
  end

  // A full-word load has nothing to extend, so sign_ext is ignored there.
  always_comb begin
    o_ld_data = '0;
    case (i_size)
      SZ_BYTE: o_ld_data = {{(WIDTH-8){i_sign_ext & w_raw_sh[7]}}, w_raw_sh[7:0]};
      SZ_HALF: o_ld_data = {{(WIDTH-16){i_sign_ext & w_raw_sh[15]}}, w_raw_sh[15:0]};
      SZ_WORD: o_ld_data = i_raw;
      default: o_ld_data = '0;
    endcase
  end

endmodule

// File: rtl/mips_dmem_sized.sv
// MEM-stage data memory with byte/half/word access, one-cycle registered reads,
// a post-reset clear sweep and a 16-bit shadow of word 0 for debug.
module mips_dmem_sized
  import mips_mem_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wd,
  output logic [WIDTH-1:0]  rd,
  output logic              rvalid,
  output logic              misalign,
  output logic              ready,
  output logic [15:0]       test_value,
  output logic [0:0]        dbg_state
);

  localparam int NB    = WIDTH / 8;
  localparam int OFF_W = clog2_f(NB);
  localparam int IDX_W = clog2_f(DEPTH);

  // Handshake: a request is taken on a rising edge where req=1 and ready=1.
  // ready is low during the clear sweep; req is ignored then. Loads answer
  // with a single-cycle rvalid pulse one edge after acceptance.

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [0:0]        r_state;
  logic [IDX_W-1:0]  r_clr_idx;
  logic              r_p_vld;
  logic              r_p_mis;
  logic [WIDTH-1:0]  r_p_data;
  logic [WIDTH-1:0]  r_rd;
  logic              r_rvalid;
  logic              r_mis;
  logic [15:0]       r_test;

  logic [OFF_W-1:0]  w_off;
  logic [ADDR_W-1:0] w_idx_full;
  logic [IDX_W-1:0]  w_idx;
  logic              w_in_range;
  logic              w_acc;
  logic              w_commit;
  logic [WIDTH-1:0]  w_raw;
  logic [NB-1:0]     w_be;
  logic [WIDTH-1:0]  w_st_data;
  logic [WIDTH-1:0]  w_ld_data;
  logic              w_legal;

  assign w_off      = addr[OFF_W-1:0];
  assign w_idx_full = addr >> OFF_W;
  assign w_idx      = w_idx_full[IDX_W-1:0];
  assign w_in_range = (w_idx_full < ADDR_W'(DEPTH));
  assign w_acc      = req & (r_state == ST_RUN);
  assign w_commit   = w_acc & we & w_legal & w_in_range;
  assign w_raw      = r_mem[w_idx];

  mips_load_align #(.WIDTH(WIDTH)) u_align (
    .i_size     (size),
    .i_off      (w_off),
    .i_wd       (wd),
    .i_raw      (w_raw),
    .i_sign_ext (sign_ext),
    .o_be       (w_be),
    .o_st_data  (w_st_data),
    .o_ld_data  (w_ld_data),
    .o_legal    (w_legal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_idx == IDX_W'(DEPTH - 1)) r_state <= ST_RUN;
          else                                r_clr_idx <= r_clr_idx + 1'b1;
        end
        ST_RUN:   r_state <= ST_RUN;
        default:  r_state <= ST_CLEAR;
      endcase
    end
  end

  // Array has no reset; the clear sweep zeroes it one word per cycle instead.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_commit) begin
      for (int k = 0; k < NB; k++) begin
        if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_st_data[8*k +: 8];
      end
    end
  end

  // Read data is captured at acceptance and presented one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p_vld  <= 1'b0;
      r_p_mis  <= 1'b0;
      r_p_data <= '0;
      r_rd     <= '0;
      r_rvalid <= 1'b0;
      r_mis    <= 1'b0;
    end else begin
      r_p_vld  <= w_acc & ~we;
      r_p_mis  <= w_acc & ~w_legal;
      if (w_acc && !we) r_p_data <= (w_legal && w_in_range) ? w_ld_data : '0;
      r_rvalid <= r_p_vld;
      r_mis    <= r_p_mis;
      if (r_p_vld) r_rd <= r_p_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_test <= '0;
    end else if (w_commit && (w_idx_full == '0)) begin
      for (int k = 0; k < 2; k++) begin
        if (w_be[k]) r_test[8*k +: 8] <= w_st_data[8*k +: 8];
      end
    end
  end

  assign rd         = r_rd;
  assign rvalid     = r_rvalid;
  assign misalign   = r_mis;
  assign ready      = (r_state == ST_RUN);
  assign test_value = r_test;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mips_dmem_sized.sv
// Directed bench for mips_dmem_sized: clear timing, sized stores/loads,
// misalignment, out-of-range, debug shadow and reset during a pending load.
module tb_mips_dmem_sized;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        rvalid;
  logic        misalign;
  logic        ready;
  logic [15:0] test_value;
  logic [0:0]  dbg_state;

  int n_cmp;
  int n_err;

  mips_dmem_sized #(.WIDTH(32), .DEPTH(256), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .size       (size),
    .sign_ext   (sign_ext),
    .addr       (addr),
    .wd         (wd),
    .rd         (rd),
    .rvalid     (rvalid),
    .misalign   (misalign),
    .ready      (ready),
    .test_value (test_value),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drivers: called #1 after a rising edge, return #1 after the accepting edge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wd = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] exp_rd,
                          input logic exp_mis);
    issue(1'b0, sz, sx, a, 32'h0);
    @(posedge clk); #1;
    check({tag, "_rd"}, rd, exp_rd);
    check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
    check({tag, "_mis"}, {31'b0, misalign}, {31'b0, exp_mis});
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'b0, rvalid}, 32'd0);
    check({tag, "_hold"}, rd, exp_rd);
  endtask

  task automatic store_chk(input string tag, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic exp_mis);
    issue(1'b1, sz, 1'b0, a, d);
    @(posedge clk); #1;
    check({tag, "_mis"}, {31'b0, misalign}, {31'b0, exp_mis});
    check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd0);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, n, 32'd256);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 32'h0; wd = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_rd", rd, 32'h0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_mis", {31'b0, misalign}, 32'd0);
    check("rst_test", {16'b0, test_value}, 32'h0);
    check("rst_state", {31'b0, dbg_state}, 32'd0);

    rst = 1'b1;
    wait_ready("ready_lat");
    check("run_state", {31'b0, dbg_state}, 32'd1);
    load_chk("ld_top", 2'b10, 1'b0, 32'h3FC, 32'h0000_0000, 1'b0);

    store_chk("st_w10", 2'b10, 32'h10, 32'hDEAD_BEEF, 1'b0);
    load_chk("ld_w10", 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    load_chk("ld_b13s", 2'b00, 1'b1, 32'h13, 32'hFFFF_FFDE, 1'b0);
    load_chk("ld_b13z", 2'b00, 1'b0, 32'h13, 32'h0000_00DE, 1'b0);
    store_chk("st_h12", 2'b01, 32'h12, 32'h0000_1234, 1'b0);
    load_chk("ld_w10b", 2'b10, 1'b1, 32'h10, 32'h1234_BEEF, 1'b0);
    load_chk("ld_h10s", 2'b01, 1'b1, 32'h10, 32'hFFFF_BEEF, 1'b0);
    load_chk("ld_h12s", 2'b01, 1'b1, 32'h12, 32'h0000_1234, 1'b0);

    load_chk("ld_w11", 2'b10, 1'b0, 32'h11, 32'h0000_0000, 1'b1);
    store_chk("st_h13", 2'b01, 32'h13, 32'h0000_FFFF, 1'b1);
    load_chk("ld_w10c", 2'b10, 1'b0, 32'h10, 32'h1234_BEEF, 1'b0);
    load_chk("ld_ill", 2'b11, 1'b0, 32'h10, 32'h0000_0000, 1'b1);
    store_chk("st_ill", 2'b11, 32'h10, 32'hFFFF_FFFF, 1'b1);
    load_chk("ld_w10d", 2'b10, 1'b0, 32'h10, 32'h1234_BEEF, 1'b0);

    issue(1'b1, 2'b10, 1'b0, 32'h0, 32'h0000_ABCD);
    check("tv_word", {16'b0, test_value}, 32'h0000_ABCD);
    issue(1'b1, 2'b00, 1'b0, 32'h1, 32'h0000_0055);
    check("tv_byte", {16'b0, test_value}, 32'h0000_55CD);
    store_chk("st_oor", 2'b10, 32'h400, 32'h1111_2222, 1'b0);
    check("tv_oor", {16'b0, test_value}, 32'h0000_55CD);
    load_chk("ld_oor", 2'b10, 1'b0, 32'h400, 32'h0000_0000, 1'b0);
    load_chk("ld_w0", 2'b10, 1'b0, 32'h0, 32'h0000_55CD, 1'b0);

    // Store followed immediately by a load of the same word, then two loads
    // back to back with no bubble between their responses.
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D);
    load_chk("b2b_st_ld", 2'b00, 1'b0, 32'h22, 32'h0000_00FE, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    check("b2b_rd1", rd, 32'h1234_BEEF);
    check("b2b_rv1", {31'b0, rvalid}, 32'd1);
    @(posedge clk); #1;
    check("b2b_rd2", rd, 32'h0000_1234);
    check("b2b_rv2", {31'b0, rvalid}, 32'd1);
    @(posedge clk); #1;
    check("b2b_end", {31'b0, rvalid}, 32'd0);

    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    rst = 1'b0;
    #1;
    check("mid_rd", rd, 32'h0);
    check("mid_rvalid", {31'b0, rvalid}, 32'd0);
    check("mid_ready", {31'b0, ready}, 32'd0);
    check("mid_test", {16'b0, test_value}, 32'h0);
    @(posedge clk); #1;
    check("mid_rvalid2", {31'b0, rvalid}, 32'd0);
    check("mid_mis2", {31'b0, misalign}, 32'd0);
    #2 rst = 1'b1;
    wait_ready("ready_lat2");
    load_chk("ld_after_clr", 2'b10, 1'b0, 32'h10, 32'h0000_0000, 1'b0);
    load_chk("ld_after_clr20", 2'b10, 1'b0, 32'h20, 32'h0000_0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_dmem_sized.md
# mips_dmem_sized

Parametrised MIPS data memory with byte/halfword/word access, little-endian byte lanes, load sign/zero extension, registered one-cycle reads and a hardware clear sequence after reset. It sits in the MEM stage in place of the flat word memory. It adds a ready/valid style request interface and a misalignment flag. It keeps the 16-bit debug tap on word 0.

## Interface
Parameters:
- WIDTH, 32, data word width in bits; a multiple of 8 and at least 32; NBYTES = WIDTH/8.
- DEPTH, 256, number of words.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  access request, sampled on the rising edge.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 full word, 11 illegal.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  ADDR_W  byte address.
- wd  in  WIDTH  store data, right-justified.
- rd  out  WIDTH  load data, extended and right-justified.
- rvalid  out  1  one-cycle pulse when rd is updated.
- misalign  out  1  one-cycle pulse on an illegal or misaligned access.
- ready  out  1  1 = requests accepted.
- test_value  out  16  bits [15:0] of word 0.

## Operation
- Addressing:
  - OFF = addr[log2(NBYTES)-1:0]; IDX = addr >> log2(NBYTES).
  - Lane k maps to bits [8k+7:8k] (little-endian).
- Accepted request: req=1 and ready=1 at a rising edge. While ready=0, req is ignored with no side effects.
- Legality:
  - Half needs OFF[0]=0.
  - Word needs OFF=0.
  - size=11 is always illegal.
  - An illegal access drops any write and pulses misalign. If it is a load, it also pulses rvalid with rd=0.
- Store:
  - Byte enables are the size-wide lane group starting at OFF.
  - The low size bytes of wd are shifted to lane OFF.
  - Unenabled lanes are preserved.
- Load: the size-wide field at lane OFF is extracted and extended per sign_ext. A full-word load ignores sign_ext.
- Out of range (IDX >= DEPTH): the store is dropped; the load returns rd=0 with rvalid=1 and no misalign.
- test_value is a shadow register, not a memory read port:
  - Updated on any committed store to IDX 0, with byte-enable-masked merge of lanes 0-1.
  - Cleared by reset.
- State machine (2 states):
  - CLEAR: a counter clr_idx runs 0..DEPTH-1 and writes zero to one word per cycle; ready=0. At clr_idx=DEPTH-1 it goes to RUN.
  - RUN: ready=1.
  - Asynchronous reset from any state goes to CLEAR with clr_idx=0.

## Timing
- Reset values: rd=0, rvalid=0, misalign=0, ready=0, test_value=0, state=CLEAR, clr_idx=0.
- After rst deasserts, ready rises after exactly DEPTH rising edges.
- Load latency: request accepted at edge N; rd, rvalid and misalign are valid after edge N+1, for one cycle.
- rd holds its last value when rvalid=0.
- Store commits at the accepting edge. A load accepted at the next edge returns the new data.
- Back-to-back requests are allowed every cycle with no bubbles.
- Reset asserted mid-transfer: the pending rvalid/misalign is discarded. Outputs go to reset values immediately and the clear restarts.

## Structure
- Shared package mips_mem_pkg holds:
  - Size codes SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL.
  - State encoding ST_CLEAR, ST_RUN.
  - The log2 helper function.
- Sub-module mips_load_align (combinational):
  - Inputs: size, OFF, wd, raw word, sign_ext.
  - Outputs: byte-enable vector, shifted store data, extended load data, legal flag.
- The top level holds the memory array, FSM, clear counter, output registers and shadow register.

## Test plan
- Reset release -> ready=0 for 256 cycles, ready=1 on cycle 256; load word at 0x3FC -> rd=0x00000000.
- Store word 0xDEADBEEF at 0x10, then load word 0x10 -> rd=0xDEADBEEF one cycle after acceptance, rvalid single pulse.
- Load byte 0x13 sign_ext=1 -> 0xFFFFFFDE. Load byte 0x13 sign_ext=0 -> 0x000000DE. Store half 0x1234 at 0x12, then load word 0x10 -> 0x1234BEEF.
- Load word at 0x11 -> misalign=1, rvalid=1, rd=0. Store half at 0x13 with 0xFFFF -> misalign=1, word 0x10 unchanged. size=11 -> misalign=1.
- Store word 0x0000ABCD at 0x0 -> test_value=0xABCD after the edge. Store byte 0x55 at 0x1 -> test_value=0x55CD. Store word at 0x400 (IDX 256) -> dropped; load there -> rd=0, misalign=0.
- Assert rst the cycle after a load is accepted -> rvalid never pulses, all outputs 0. After release, the full clear runs and 0x10 reads 0.
